// File: rtl/sram_loader_if.sv
// Handshake and SRAM bus bundle for sram_loader.
// slave: loader side; master: stream source / board side.
interface sram_loader_if #(
    parameter int ADDR_W = 20
);
    logic              Start;
    logic [15:0]       Base_addr;
    logic [15:0]       Word_count;
    logic [15:0]       In_data;
    logic              In_valid;
    logic              In_ready;
    logic              CE;
    logic              UB;
    logic              LB;
    logic              OE;
    logic              WE;
    logic [ADDR_W-1:0] ADDR;
    logic [15:0]       Data_write;
    logic              Data_oe;
    logic              Busy;
    logic              Done;
    logic              Hold_cpu;
    logic [15:0]       Words_written;
    logic [15:0]       Checksum;

    modport slave (
        input  Start, Base_addr, Word_count, In_data, In_valid,
        output In_ready, CE, UB, LB, OE, WE, ADDR, Data_write,
        output Data_oe, Busy, Done, Hold_cpu, Words_written, Checksum
    );

    modport master (
        output Start, Base_addr, Word_count, In_data, In_valid,
        input  In_ready, CE, UB, LB, OE, WE, ADDR, Data_write,
        input  Data_oe, Busy, Done, Hold_cpu, Words_written, Checksum
    );
endinterface

// File: rtl/sram_loader.sv
// Streams 16-bit words into consecutive SRAM addresses, holding the CPU off.
// Ports: Clk, Reset (sync, active-low), bus (sram_loader_if.slave).
module sram_loader #(
    parameter int WE_CYCLES = 1,
    parameter int ADDR_W    = 20
) (
    input  logic          Clk,
    input  logic          Reset,
    sram_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [15:0] count_q, count_d;
    logic [15:0] ww_q, ww_d;
    logic [15:0] csum_q, csum_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  scnt_q, scnt_d;

    logic [15:0] ww_inc;
    logic        wr_phase;

    assign ww_inc = ww_q + 16'd1;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        ww_d    = ww_q;
        csum_d  = csum_q;
        data_d  = data_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    base_d  = bus.Base_addr;
                    count_d = bus.Word_count;
                    ww_d    = 16'd0;
                    csum_d  = 16'd0;
                    // An empty load finishes without touching the SRAM.
                    state_d = (bus.Word_count == 16'd0) ? DONE : WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (bus.In_valid) begin
                    data_d  = bus.In_data;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                scnt_d  = 4'(WE_CYCLES - 1);
                state_d = STROBE;
            end
            STROBE: begin
                if (scnt_q == 4'd0) begin
                    state_d = HOLD;
                end else begin
                    scnt_d = scnt_q - 4'd1;
                end
            end
            HOLD: begin
                ww_d    = ww_inc;
                csum_d  = csum_q + data_q;
                state_d = (ww_inc == count_q) ? DONE : WAIT_DATA;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            base_q  <= 16'd0;
            count_q <= 16'd0;
            ww_q    <= 16'd0;
            csum_q  <= 16'd0;
            data_q  <= 16'd0;
            scnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            ww_q    <= ww_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            scnt_q  <= scnt_d;
        end
    end

    // Chip is selected and data driven across SETUP, STROBE and HOLD so
    // address and data bracket the WE pulse on both sides.
    assign wr_phase = (state_q == SETUP) || (state_q == STROBE) ||
                      (state_q == HOLD);

    assign bus.In_ready      = (state_q == WAIT_DATA);
    assign bus.CE            = ~wr_phase;
    assign bus.UB            = ~wr_phase;
    assign bus.LB            = ~wr_phase;
    assign bus.OE            = 1'b1;
    assign bus.WE            = ~(state_q == STROBE);
    assign bus.ADDR          = {{(ADDR_W-16){1'b0}}, base_q + ww_q};
    assign bus.Data_write    = data_q;
    assign bus.Data_oe       = wr_phase;
    assign bus.Busy          = (state_q == WAIT_DATA) || wr_phase;
    assign bus.Hold_cpu      = bus.Busy;
    assign bus.Done          = (state_q == DONE);
    assign bus.Words_written = ww_q;
    assign bus.Checksum      = csum_q;

endmodule

// File: tb/tb_sram_loader.sv
// Self-checking bench for sram_loader (WE_CYCLES=1 and WE_CYCLES=3 builds).
// Drives loads from a vector table plus directed reset/empty-load sequences.
module tb_sram_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        start;
    logic [15:0] base;
    logic [15:0] count;
    logic [15:0] in_data;
    logic        in_valid;

    sram_loader_if #(.ADDR_W(20)) if0 ();
    sram_loader_if #(.ADDR_W(20)) if3 ();

    assign if0.Start      = start & ~sel;
    assign if0.Base_addr  = base;
    assign if0.Word_count = count;
    assign if0.In_data    = in_data;
    assign if0.In_valid   = in_valid & ~sel;
    assign if3.Start      = start & sel;
    assign if3.Base_addr  = base;
    assign if3.Word_count = count;
    assign if3.In_data    = in_data;
    assign if3.In_valid   = in_valid & sel;

    sram_loader #(.WE_CYCLES(1), .ADDR_W(20)) u0 (
        .Clk(clk), .Reset(rst_n), .bus(if0.slave)
    );
    sram_loader #(.WE_CYCLES(3), .ADDR_W(20)) u3 (
        .Clk(clk), .Reset(rst_n), .bus(if3.slave)
    );

    logic        m_ready, m_we, m_oe, m_doe, m_busy, m_hold, m_done;
    logic [19:0] m_addr;
    logic [15:0] m_data, m_ww, m_csum;

    assign m_ready = sel ? if3.In_ready : if0.In_ready;
    assign m_we    = sel ? if3.WE : if0.WE;
    assign m_oe    = sel ? if3.OE : if0.OE;
    assign m_doe   = sel ? if3.Data_oe : if0.Data_oe;
    assign m_busy  = sel ? if3.Busy : if0.Busy;
    assign m_hold  = sel ? if3.Hold_cpu : if0.Hold_cpu;
    assign m_done  = sel ? if3.Done : if0.Done;
    assign m_addr  = sel ? if3.ADDR : if0.ADDR;
    assign m_data  = sel ? if3.Data_write : if0.Data_write;
    assign m_ww    = sel ? if3.Words_written : if0.Words_written;
    assign m_csum  = sel ? if3.Checksum : if0.Checksum;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write-pulse monitor: logs address/data/time/length of every WE-low run.
    logic [19:0] wa [64];
    logic [15:0] wd [64];
    int          wt [64];
    int          wl [64];
    int          nw = 0;
    int          nl = 0;
    int          run = 0;
    int          v_stab = 0;
    int          v_doe = 0;
    int          v_oe = 0;
    int          v_hold = 0;
    int          busy_cnt = 0;
    logic        we_prev = 1'b1;
    logic [19:0] a0;
    logic [15:0] d0;

    always @(negedge clk) begin
        if (!m_we) begin
            if (we_prev) begin
                if (nw < 64) begin
                    wa[nw] = m_addr;
                    wd[nw] = m_data;
                    wt[nw] = cyc;
                end
                nw++;
                run = 1;
                a0 = m_addr;
                d0 = m_data;
            end else begin
                run++;
                if (m_addr !== a0 || m_data !== d0) v_stab++;
            end
            if (!m_doe) v_doe++;
        end else if (!we_prev) begin
            if (nl < 64) wl[nl] = run;
            nl++;
        end
        if (!m_oe) v_oe++;
        if (m_hold !== m_busy) v_hold++;
        if (m_busy) busy_cnt++;
        we_prev = m_we;
    end

    typedef struct {
        bit              sel;
        logic [15:0]     base;
        logic [15:0]     count;
        logic [3:0][15:0] d;
        int              gap;
        bit              mid;
        logic [3:0][19:0] ea;
        logic [15:0]     csum;
    } vec_t;

    function automatic vec_t mk(
        input bit s, input logic [15:0] b, input logic [15:0] c,
        input logic [15:0] x0, input logic [15:0] x1,
        input logic [15:0] x2, input logic [15:0] x3,
        input int g, input bit m,
        input logic [19:0] e0, input logic [19:0] e1,
        input logic [19:0] e2, input logic [19:0] e3,
        input logic [15:0] cs);
        vec_t r;
        r.sel   = s;
        r.base  = b;
        r.count = c;
        r.d     = {x3, x2, x1, x0};
        r.gap   = g;
        r.mid   = m;
        r.ea    = {e3, e2, e1, e0};
        r.csum  = cs;
        return r;
    endfunction

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!m_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(tag, m_ready, 1);
    endtask

    task automatic run_load(input vec_t v, input string tag);
        int n0;
        int k;
        int wl_exp;
        int sp_exp;
        logic ok;
        wl_exp = v.sel ? 3 : 1;
        sp_exp = v.sel ? 6 : 4;
        @(negedge clk);
        sel = v.sel;
        @(negedge clk);
        n0 = nw;
        base  = v.base;
        count = v.count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(v.count); i++) begin
            if (v.gap > 0 && i > 0) begin
                in_valid = 1'b0;
                wait_ready($sformatf("%s.gapready%0d", tag, i));
                ok = 1'b1;
                for (int j = 0; j < v.gap; j++) begin
                    if (!m_ready || !m_we) ok = 1'b0;
                    if (v.mid && j == 0) begin
                        start = 1'b1;
                        base  = 16'h1234;
                        count = 16'd9;
                    end else begin
                        start = 1'b0;
                        base  = v.base;
                        count = v.count;
                    end
                    @(negedge clk);
                end
                start = 1'b0;
                check($sformatf("%s.gap%0d", tag, i), ok, 1);
            end
            in_data  = v.d[i];
            in_valid = 1'b1;
            wait_ready($sformatf("%s.ready%0d", tag, i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        k = 0;
        while (!m_done && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".done"}, m_done, 1);
        check({tag, ".busy"}, m_busy, 0);
        check({tag, ".nwrites"}, nw - n0, 32'(v.count));
        for (int i = 0; i < int'(v.count) && n0 + i < 64; i++) begin
            check($sformatf("%s.addr%0d", tag, i), wa[n0+i], v.ea[i]);
            check($sformatf("%s.data%0d", tag, i), wd[n0+i], v.d[i]);
            check($sformatf("%s.welen%0d", tag, i), wl[n0+i], wl_exp);
            if (i > 0 && v.gap == 0)
                check($sformatf("%s.space%0d", tag, i),
                      wt[n0+i] - wt[n0+i-1], sp_exp);
        end
        check({tag, ".ww"}, m_ww, v.count);
        check({tag, ".csum"}, m_csum, v.csum);
    endtask

    vec_t vt [5];
    int   b0;
    int   n0;

    initial begin
        vt[0] = mk(0, 16'h3000, 16'd3, 16'h1111, 16'h2222, 16'h3333, 16'h0,
                   0, 0, 20'h03000, 20'h03001, 20'h03002, 20'h0, 16'h6666);
        vt[1] = mk(0, 16'hFFFF, 16'd2, 16'hFFFF, 16'h0002, 16'h0, 16'h0,
                   0, 0, 20'h0FFFF, 20'h00000, 20'h0, 20'h0, 16'h0001);
        vt[2] = mk(0, 16'h0100, 16'd4, 16'h0001, 16'h0010, 16'h0100,
                   16'h1000, 5, 1, 20'h00100, 20'h00101, 20'h00102,
                   20'h00103, 16'h1111);
        vt[3] = mk(0, 16'h8000, 16'd1, 16'hABCD, 16'h0, 16'h0, 16'h0,
                   0, 0, 20'h08000, 20'h0, 20'h0, 20'h0, 16'hABCD);
        vt[4] = mk(1, 16'h0500, 16'd2, 16'hBEEF, 16'h0123, 16'h0, 16'h0,
                   0, 0, 20'h00500, 20'h00501, 20'h0, 20'h0, 16'hC012);

        rst_n    = 1'b0;
        sel      = 1'b0;
        start    = 1'b0;
        base     = 16'h0;
        count    = 16'h0;
        in_data  = 16'h0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        check("rst.in_ready", if0.In_ready, 0);
        check("rst.strobes",
              {if0.CE, if0.UB, if0.LB, if0.OE, if0.WE}, 5'h1F);
        check("rst.addr", if0.ADDR, 0);
        check("rst.wdata", if0.Data_write, 0);
        check("rst.data_oe", if0.Data_oe, 0);
        check("rst.busy", if0.Busy, 0);
        check("rst.done", if0.Done, 0);
        check("rst.hold", if0.Hold_cpu, 0);
        check("rst.ww", if0.Words_written, 0);
        check("rst.csum", if0.Checksum, 0);
        check("rst.we3", if3.WE, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty load: straight to DONE, no Busy, no strobes.
        b0 = busy_cnt;
        n0 = nw;
        base  = 16'h1234;
        count = 16'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("empty.done", m_done, 1);
        check("empty.busy", m_busy, 0);
        check("empty.ww", m_ww, 0);
        check("empty.csum", m_csum, 0);
        repeat (3) @(negedge clk);
        check("empty.busycnt", busy_cnt - b0, 0);
        check("empty.nwrites", nw - n0, 0);

        for (int t = 0; t < 5; t++)
            run_load(vt[t], $sformatf("vec%0d", t));

        // Reset while word 2 of 4 is being strobed.
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);
        base  = 16'h0200;
        count = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_data  = 16'hAAAA;
        in_valid = 1'b1;
        wait_ready("rst2.ready0");
        @(negedge clk);
        in_data = 16'hBBBB;
        wait_ready("rst2.ready1");
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst2.pre_we", m_we, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2.we", m_we, 1);
        check("rst2.data_oe", m_doe, 0);
        check("rst2.busy", m_busy, 0);
        check("rst2.ww", m_ww, 0);
        check("rst2.csum", m_csum, 0);
        check("rst2.done", m_done, 0);
        run_load(mk(0, 16'h0040, 16'd1, 16'h5A5A, 16'h0, 16'h0, 16'h0,
                    0, 0, 20'h00040, 20'h0, 20'h0, 20'h0, 16'h5A5A),
                 "after_rst");

        repeat (2) @(negedge clk);
        check("inv.stable", v_stab, 0);
        check("inv.we_doe", v_doe, 0);
        check("inv.oe", v_oe, 0);
        check("inv.hold_busy", v_hold, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
